predictor_update_sched: RTL
===========================

Name: predictor_update_sched

Overview:
- Owns the 2-bit counter table used by the branch predictor, and is its only writer.
- After reset, sweeps every table entry to weakly-not-taken (2'b01).
- Buffers branch-resolution updates from the Reorder Buffer in a FIFO.
- Serialises those updates into a pipelined read-modify-write on the table's single read/write port pair, applying saturating arithmetic and forwarding for back-to-back hits on the same entry.

Parameters:
LOCAL_WIDTH, 12, table index width; entry index = instruction address bits [LOCAL_WIDTH+1:2]
LOCAL_SIZE, 2**LOCAL_WIDTH, number of table entries
FIFO_DEPTH, 4, update FIFO entries (power of two, >=2)

Ports:
clockIn  input  1  single clock
resetIn  input  1  synchronous reset, active-low (0 = reset, sampled on posedge clockIn)
updateValid  input  1  ROB presents a resolved branch this cycle
updateInstr  input  32  address of the resolved branch
taken  input  1  resolved direction
updateReady  output  1  FIFO can accept; an update transfers when updateValid && updateReady
tableRdEn  output  1  table read request
tableRdIndex  output  LOCAL_WIDTH  read index
tableRdData  input  2  counter value, valid the cycle after tableRdEn
tableWrEn  output  1  table write strobe
tableWrIndex  output  LOCAL_WIDTH  write index
tableWrData  output  2  value written
initDone  output  1  high once the sweep is complete; the predictor gates lookups with it
pendingCount  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Table contract: synchronous read with 1-cycle latency. On a same-edge read/write collision the read returns the old data.
- Reset (resetIn==0 at an edge):
  - FIFO emptied, pipeline squashed, state <= INIT, sweep counter <= 0.
  - Output values: tableWrEn=0, tableRdEn=0, initDone=0, pendingCount=0, updateReady=0.
  - Reset asserted mid-operation discards all queued and in-flight updates. No partial write may occur after the reset edge.
- INIT state:
  - Each cycle: tableWrEn=1, tableWrIndex=sweep counter, tableWrData=2'b01; counter increments.
  - After index LOCAL_SIZE-1 is written, next state is RUN and initDone=1 from that cycle on. The sweep takes exactly LOCAL_SIZE cycles.
  - FIFO accepts updates during INIT (updateReady = not full) but does not drain.
- RUN state, 2-stage pipeline:
  - S0: if FIFO is non-empty, pop the head, tableRdEn=1, tableRdIndex=head index; latch index and taken into S1.
  - S1: next = taken ? sat_inc(cur) : sat_dec(cur). tableWrEn=1, tableWrIndex=S1 index, tableWrData=next.
  - Saturation: 2'b11 + taken stays 2'b11; 2'b00 + not-taken stays 2'b00. No wrap-around.
  - Forwarding: cur = tableRdData, except when the previous S1 wrote the same index this entry read in the same cycle; then cur = that written value.
  - Throughput: 1 update per cycle sustained, including consecutive same-index updates.
- FIFO:
  - updateReady = !full.
  - Push and pop in the same cycle while full is legal only if the pop occurs; updateReady still reflects full (no combinational ready-from-pop).
  - Simultaneous push and pop when non-empty leaves pendingCount unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Index extraction: updateInstr[LOCAL_WIDTH+1:2]; bits [1:0] and upper bits are ignored.
- tableWrEn is never high in RUN unless S1 holds a valid entry. tableRdEn is never high in INIT.

Test Plan:
- LOCAL_WIDTH=4: release reset -> tableWrEn high for 16 cycles, indices 0..15, data 2'b01. initDone rises in the cycle after index 15 is written. Zero writes follow while the FIFO is empty.
- After init, 3 taken updates to 0x0000_0010 on consecutive cycles -> writes at index 4 of 2'b10, 2'b11, 2'b11, one cycle apart. Forwarding is used, and saturation holds at 2'b11.
- After init, 2 not-taken updates to 0x14 -> index 5 written 2'b00 then 2'b00; no wrap to 2'b11.
- Push 6 updates during INIT with FIFO_DEPTH=4 -> 4 accepted, updateReady=0 while full, pendingCount=4. The queued updates are applied in order starting the cycle initDone rises.
- Updates to 0x10 and 0x50 (both index 4 at LOCAL_WIDTH=4), taken then not-taken -> 2'b10 then 2'b01.
- Assert resetIn=0 with 3 updates queued and one in S1 -> no table write on the following edges. pendingCount=0, initDone=0, and a full re-sweep starts from index 0.

Source files
------------

// File: rtl/predictor_update_sched.sv
// Branch-predictor counter table owner: sweeps the table to weakly-not-taken
// after reset, queues resolved-branch updates and applies them through a
// 2-stage read-modify-write pipeline with same-index forwarding.
module predictor_update_sched #(
    parameter int LOCAL_WIDTH = 12,
    parameter int LOCAL_SIZE  = 2 ** LOCAL_WIDTH,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                            clockIn,
    input  logic                            resetIn,
    input  logic                            updateValid,
    input  logic [31:0]                     updateInstr,
    input  logic                            taken,
    output logic                            updateReady,
    output logic                            tableRdEn,
    output logic [LOCAL_WIDTH-1:0]          tableRdIndex,
    input  logic [1:0]                      tableRdData,
    output logic                            tableWrEn,
    output logic [LOCAL_WIDTH-1:0]          tableWrIndex,
    output logic [1:0]                      tableWrData,
    output logic                            initDone,
    output logic [$clog2(FIFO_DEPTH):0]     pendingCount
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [LOCAL_WIDTH-1:0] LAST_IDX = LOCAL_WIDTH'(LOCAL_SIZE - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                 state_q, state_d;
    logic [LOCAL_WIDTH-1:0] sweep_q, sweep_d;
    logic                   sweep_act_q, sweep_act_d;
    logic                   init_done_q, init_done_d;
    logic                   ready_q, ready_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [LOCAL_WIDTH-1:0] s1_idx_q, s1_idx_d;
    logic                   s1_taken_q, s1_taken_d;
    logic                   fwd_q, fwd_d;
    logic [1:0]             fwd_data_q, fwd_data_d;

    logic [LOCAL_WIDTH-1:0] fifo_idx_q [FIFO_DEPTH];
    logic [LOCAL_WIDTH-1:0] fifo_idx_d [FIFO_DEPTH];
    logic                   fifo_taken_q [FIFO_DEPTH];
    logic                   fifo_taken_d [FIFO_DEPTH];

    logic                   push, pop;
    logic [LOCAL_WIDTH-1:0] in_idx, head_idx;
    logic                   head_taken;
    logic [1:0]             cur, s1_next;
    logic                   unused_instr_bits;

    assign in_idx            = updateInstr[LOCAL_WIDTH+1:2];
    assign unused_instr_bits = ^{updateInstr[31:LOCAL_WIDTH+2], updateInstr[1:0]};
    assign push              = updateValid && ready_q;
    assign pop               = (state_q == ST_RUN) && (count_q != '0);
    assign head_idx          = fifo_idx_q[rd_ptr_q];
    assign head_taken        = fifo_taken_q[rd_ptr_q];

    // FIFO storage: each slot captures the incoming update when the write pointer selects it
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            always_comb begin
                fifo_idx_d[gi]   = fifo_idx_q[gi];
                fifo_taken_d[gi] = fifo_taken_q[gi];
                if (push && (wr_ptr_q == AW'(gi))) begin
                    fifo_idx_d[gi]   = in_idx;
                    fifo_taken_d[gi] = taken;
                end
            end

            // Slot register; payload only, so no reset needed
            always_ff @(posedge clockIn) begin
                fifo_idx_q[gi]   <= fifo_idx_d[gi];
                fifo_taken_q[gi] <= fifo_taken_d[gi];
            end
        end
    endgenerate

    // S1 counter update; a same-edge collision with the previous write returns stale data, so forward it
    always_comb begin
        cur = fwd_q ? fwd_data_q : tableRdData;
        if (s1_taken_q) s1_next = (cur == 2'b11) ? 2'b11 : cur + 2'b01;
        else            s1_next = (cur == 2'b00) ? 2'b00 : cur - 2'b01;
    end

    // Next-state logic for sweep FSM, FIFO bookkeeping and pipeline stages
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        sweep_act_d = sweep_act_q;
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ready_d     = (count_d != CW'(FIFO_DEPTH));
        s1_valid_d  = pop;
        s1_idx_d    = head_idx;
        s1_taken_d  = head_taken;
        fwd_d       = pop && s1_valid_q && (s1_idx_q == head_idx);
        fwd_data_d  = s1_next;
        if (state_q == ST_INIT) begin
            if (sweep_act_q) begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == LAST_IDX) begin
                    state_d     = ST_RUN;
                    sweep_act_d = 1'b0;
                end
            end else begin
                sweep_act_d = 1'b1;
            end
        end
        init_done_d = (state_d == ST_RUN);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clockIn) begin
        if (!resetIn) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            sweep_act_q <= 1'b0;
            init_done_q <= 1'b0;
            ready_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            s1_taken_q  <= 1'b0;
            fwd_q       <= 1'b0;
            fwd_data_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            sweep_act_q <= sweep_act_d;
            init_done_q <= init_done_d;
            ready_q     <= ready_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            s1_valid_q  <= s1_valid_d;
            s1_idx_q    <= s1_idx_d;
            s1_taken_q  <= s1_taken_d;
            fwd_q       <= fwd_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    // Table strobes are masked by resetIn so an in-flight write cannot land on the reset edge
    assign tableRdEn    = resetIn && pop;
    assign tableRdIndex = head_idx;
    assign tableWrEn    = resetIn && ((state_q == ST_INIT) ? sweep_act_q : s1_valid_q);
    assign tableWrIndex = (state_q == ST_INIT) ? sweep_q : s1_idx_q;
    assign tableWrData  = (state_q == ST_INIT) ? 2'b01 : s1_next;
    assign initDone     = init_done_q;
    assign updateReady  = ready_q;
    assign pendingCount = count_q;
endmodule
